// File: rtl/alu_result_queue.sv
// Buffers ALU results with derived {N,Z,C,V} flags in a DEPTH-entry FIFO; entries appear on out_* one cycle after push.
// Backpressure: in_ready = !full from registered state only (no pop-through when full); out_* held stable until out_ready.
module alu_result_queue #(
  parameter int         W      = 32,
  parameter int         DEPTH  = 4,
  parameter logic [2:0] OP_ADD = 3'b100,
  parameter logic [2:0] OP_SUB = 3'b101
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W:0]               in_result,
  input  logic                     in_a_msb,
  input  logic                     in_b_msb,
  input  logic [2:0]               in_alop,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W-1:0]             out_data,
  output logic [3:0]               out_flags,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               ovf_count,
  input  logic                     ovf_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W+3:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [7:0]    r_ovf_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_n;
  logic w_z;
  logic w_c;
  logic w_v;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  assign w_push    = in_valid && !w_full;
  assign w_pop     = out_ready && !w_empty;

  always_comb begin
    w_n = in_result[W-1];
    w_z = (in_result[W-1:0] == '0);
    w_c = in_result[W];
    w_v = 1'b0;
    // For subtract, result[W] already carries the borrow, so only V needs operand signs
    if (in_alop == OP_ADD) begin
      w_v = (in_a_msb == in_b_msb) && (in_result[W-1] != in_a_msb);
    end else if (in_alop == OP_SUB) begin
      w_v = (in_a_msb != in_b_msb) && (in_result[W-1] != in_a_msb);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {w_n, w_z, w_c, w_v, in_result[W-1:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_count <= '0;
    end else if (ovf_clr) begin
      r_ovf_count <= '0;
    end else if (w_push && w_v && (r_ovf_count != 8'hFF)) begin
      r_ovf_count <= r_ovf_count + 8'd1;
    end
  end

  assign out_data  = w_empty ? '0 : r_mem[r_rd_ptr][W-1:0];
  assign out_flags = w_empty ? '0 : r_mem[r_rd_ptr][W+3:W];
  assign count     = r_count;
  assign ovf_count = r_ovf_count;

endmodule

// File: tb/tb_alu_result_queue.sv
// Directed bench for alu_result_queue: flags, ordering, full/empty, ovf saturation, async reset.
module tb_alu_result_queue;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W:0]    in_result;
  logic          in_a_msb;
  logic          in_b_msb;
  logic [2:0]    in_alop;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [3:0]    out_flags;
  logic [2:0]    count;
  logic [7:0]    ovf_count;
  logic          ovf_clr;

  int checks = 0;
  int errs   = 0;

  alu_result_queue #(.W(W), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_a_msb(in_a_msb), .in_b_msb(in_b_msb), .in_alop(in_alop),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_flags(out_flags),
    .count(count), .ovf_count(ovf_count), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [W:0] res, input logic a, input logic b, input logic [2:0] op);
    in_result = res; in_a_msb = a; in_b_msb = b; in_alop = op; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop1();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_result = '0; in_a_msb = 1'b0; in_b_msb = 1'b0;
    in_alop = 3'b000; out_ready = 1'b0; ovf_clr = 1'b0;
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_ovf", ovf_count, 0);
    chk("rst_data", out_data, 0);
    chk("rst_flags", out_flags, 0);
    @(negedge clk) rst_n = 1'b1;

    // Zero result: only Z set; no same-cycle bypass
    in_result = 33'h0_0000_0000; in_alop = 3'b100; in_valid = 1'b1;
    #1 chk("no_bypass", out_valid, 0);
    tick();
    in_valid = 1'b0;
    chk("zero_valid", out_valid, 1);
    chk("zero_data", out_data, 0);
    chk("zero_flags", out_flags, 4'b0100);
    chk("zero_count", count, 1);
    pop1();
    chk("zero_popped", out_valid, 0);

    push1(33'h0_8000_0000, 1'b0, 1'b0, 3'b100);
    chk("add_ovf_flags", out_flags, 4'b1001);
    chk("add_ovf_cnt", ovf_count, 1);
    pop1();
    push1(33'h0_8000_0000, 1'b0, 1'b0, 3'b000);
    chk("other_op_flags", out_flags, 4'b1000);
    chk("other_op_ovf", ovf_count, 1);
    pop1();
    push1(33'h1_7FFF_FFFF, 1'b1, 1'b0, 3'b101);
    chk("sub_flags", out_flags, 4'b0011);
    chk("sub_data", out_data, 32'h7FFF_FFFF);
    pop1();

    // Fill to DEPTH, reject extra, pop while full does not admit a push
    in_alop = 3'b000; in_a_msb = 1'b0; in_b_msb = 1'b0; in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_result = 33'(i);
      tick();
    end
    chk("full_in_ready", in_ready, 0);
    chk("full_count", count, 4);
    in_result = 33'd5;
    tick();
    chk("reject_count", count, 4);
    chk("stable_head", out_data, 1);
    in_result = 33'd99; out_ready = 1'b1;
    chk("full_pop_in_ready", in_ready, 0);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("after_full_pop_count", count, 3);
    chk("after_full_pop_ready", in_ready, 1);
    for (int v = 2; v <= 4; v++) begin
      chk("drain_order", out_data, 64'(v));
      pop1();
    end
    chk("drain_empty", out_valid, 0);
    chk("drain_data_zero", out_data, 0);

    // Steady push+pop at count 2 wraps both pointers
    in_valid = 1'b1;
    in_result = 33'd10; tick();
    in_result = 33'd11; tick();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_result = 33'(12 + i);
      chk("stream_head", out_data, 64'(10 + i));
      tick();
      chk("stream_count", count, 2);
    end
    in_valid = 1'b0;
    chk("stream_tail0", out_data, 20);
    tick();
    chk("stream_tail1", out_data, 21);
    tick();
    out_ready = 1'b0;
    chk("stream_empty", out_valid, 0);

    // Overflow counter saturation and clear priority
    chk("ovf_before_sat", ovf_count, 2);
    in_result = 33'h0_8000_0000; in_a_msb = 1'b0; in_b_msb = 1'b0; in_alop = 3'b100;
    in_valid = 1'b1; out_ready = 1'b1;
    repeat (300) tick();
    chk("ovf_saturated", ovf_count, 255);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr_priority", ovf_count, 0);
    tick();
    chk("ovf_after_clr", ovf_count, 1);
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    chk("sat_drained", out_valid, 0);

    // Asynchronous reset mid-stream
    in_alop = 3'b000;
    push1(33'h100, 1'b0, 1'b0, 3'b000);
    push1(33'h101, 1'b0, 1'b0, 3'b000);
    push1(33'h102, 1'b0, 1'b0, 3'b000);
    chk("pre_rst_count", count, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_count", count, 0);
    chk("async_rst_ready", in_ready, 1);
    chk("async_rst_data", out_data, 0);
    @(negedge clk) rst_n = 1'b1;
    push1(33'h200, 1'b0, 1'b0, 3'b000);
    chk("post_rst_count", count, 1);
    chk("post_rst_data", out_data, 32'h200);
    pop1();
    chk("post_rst_empty", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
